// File: rtl/mul16_seq_pkg.sv
// rtl/mul16_seq_pkg.sv - shared state encoding and ALU control words for mul16_seq
package mul16_seq_pkg;

    localparam int MUL_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // ALU control word {zx, nx, zy, ny, f, no} selecting x + y
    localparam logic [5:0] ALU_OP_ADD = 6'b000010;

endpackage

// File: rtl/mul16_seq_alu.sv
// rtl/mul16_seq_alu.sv - 16-bit Hack-style combinational ALU with output enable
module mul16_seq_alu (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    input  logic        en,
    output logic [15:0] out
);

    logic [15:0] x_z;
    logic [15:0] x_n;
    logic [15:0] y_z;
    logic [15:0] y_n;
    logic [15:0] f_out;
    logic [15:0] res;

    // Zero/negate each operand, add or AND, optionally negate; gated by en
    always_comb begin
        x_z   = zx ? 16'h0000 : x;
        x_n   = nx ? ~x_z : x_z;
        y_z   = zy ? 16'h0000 : y;
        y_n   = ny ? ~y_z : y_z;
        f_out = f ? (x_n + y_n) : (x_n & y_n);
        res   = no ? ~f_out : f_out;
        out   = en ? res : 16'h0000;
    end

endmodule

// File: rtl/mul16_seq.sv
// rtl/mul16_seq.sv - sequential 16x16 shift-and-add multiplier (low word); optional MUL16_SEQ_EARLY_EXIT_EN
module mul16_seq
    import mul16_seq_pkg::*;
#(
    parameter int CNT_W = 5,
    parameter int ITERS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic        product_zr
);

    state_t             state_q, state_d;
    logic [15:0]        acc_q, acc_d;
    logic [15:0]        mcand_q, mcand_d;
    logic [15:0]        mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        product_q, product_d;
    logic               product_zr_q, product_zr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               last_iter;
    logic [15:0]        alu_out;

    // Accumulate step: acc + mcand through the shared ALU, only active in RUN
    mul16_seq_alu u_alu (
        .x   (acc_q),
        .y   (mcand_q),
        .zx  (ALU_OP_ADD[5]),
        .nx  (ALU_OP_ADD[4]),
        .zy  (ALU_OP_ADD[3]),
        .ny  (ALU_OP_ADD[2]),
        .f   (ALU_OP_ADD[1]),
        .no  (ALU_OP_ADD[0]),
        .en  (state_q == RUN),
        .out (alu_out)
    );

    // Next-state and datapath; outputs are derived from the next state so they register cleanly
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        cnt_d        = cnt_q;
        product_d    = product_q;
        product_zr_d = product_zr_q;
        last_iter    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = a;
                    mplier_d = b;
                    acc_d    = 16'h0000;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (mplier_q[0]) begin
                    acc_d = alu_out;
                end
                mcand_d   = mcand_q << 1;
                mplier_d  = mplier_q >> 1;
                cnt_d     = cnt_q + CNT_W'(1);
                last_iter = (cnt_q == CNT_W'(ITERS - 1));
`ifdef MUL16_SEQ_EARLY_EXIT_EN
                // No remaining multiplier bits means acc is already final
                last_iter = last_iter || (mplier_d == 16'h0000);
`endif
                if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Product is latched on the edge entering DONE so it is valid alongside done
        if (state_d == DONE) begin
            product_d    = acc_d;
            product_zr_d = (acc_d == 16'h0000);
        end
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // FSM and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_q        <= 16'h0000;
            mcand_q      <= 16'h0000;
            mplier_q     <= 16'h0000;
            cnt_q        <= '0;
            product_q    <= 16'h0000;
            product_zr_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            cnt_q        <= cnt_d;
            product_q    <= product_d;
            product_zr_q <= product_zr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign product    = product_q;
    assign product_zr = product_zr_q;

endmodule

// File: tb/tb_mul16_seq.sv
// tb/tb_mul16_seq.sv - scoreboard testbench for mul16_seq
module tb_mul16_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a_i;
    logic [15:0] b_i;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic        product_zr;

    int          n_checks;
    int          n_fail;
    logic [15:0] exp_q[$];

    mul16_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a_i),
        .b          (b_i),
        .busy       (busy),
        .done       (done),
        .product    (product),
        .product_zr (product_zr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Cycles from the start edge to the done cycle
    function automatic int exp_latency(input logic [15:0] b);
        int runs;
        runs = 16;
`ifdef MUL16_SEQ_EARLY_EXIT_EN
        runs = 1;
        for (int i = 1; i < 16; i++) begin
            if ((b >> i) != 16'h0000) runs = i + 1;
        end
`endif
        return runs + 1;
    endfunction

    // Result monitor: every done pops the oldest expected product
    always @(negedge clk) begin
        logic [15:0] e;
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("product", {16'h0, product}, {16'h0, e});
                check_eq("product_zr", {31'h0, product_zr}, {31'h0, (e == 16'h0000)});
            end
        end
    end

    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input int inject_at, input int reset_at);
        logic [31:0] full;
        logic [15:0] exp_p;
        int          exp_k;
        bit          seen;
        full  = {16'h0, a} * {16'h0, b};
        exp_p = full[15:0];
        exp_k = exp_latency(b);
        @(negedge clk);
        a_i   = a;
        b_i   = b;
        start = 1'b1;
        exp_q.push_back(exp_p);
        seen  = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            a_i = 16'($urandom);
            b_i = 16'($urandom);
            if (reset_at == k) begin
                start = 1'b0;
                rst   = 1'b1;
                #1;
                check_eq("rst_busy", {31'h0, busy}, 32'd0);
                check_eq("rst_done", {31'h0, done}, 32'd0);
                check_eq("rst_product", {16'h0, product}, 32'd0);
                check_eq("rst_product_zr", {31'h0, product_zr}, 32'd1);
                void'(exp_q.pop_back());
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                repeat (25) @(negedge clk);
                check_eq("no_done_after_rst", {31'h0, done}, 32'd0);
                return;
            end
            if (inject_at == k) begin
                start = 1'b1;
                a_i   = 16'd7;
                b_i   = 16'd7;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                seen = 1'b1;
                check_eq("latency", k, exp_k);
            end else if (k < exp_k) begin
                check_eq("busy_run", {31'h0, busy}, 32'd1);
            end
        end
        start = 1'b0;
        if (!seen) check_eq("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
        check_eq("done_one_cycle", {31'h0, done}, 32'd0);
        check_eq("busy_after", {31'h0, busy}, 32'd0);
        check_eq("product_hold", {16'h0, product}, {16'h0, exp_p});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        a_i      = 16'h0;
        b_i      = 16'h0;
        repeat (2) @(negedge clk);
        check_eq("reset_busy", {31'h0, busy}, 32'd0);
        check_eq("reset_done", {31'h0, done}, 32'd0);
        check_eq("reset_product", {16'h0, product}, 32'd0);
        check_eq("reset_product_zr", {31'h0, product_zr}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        run_op(16'd3, 16'd5, 0, 0);
        run_op(16'hFFFF, 16'hFFFF, 0, 0);
        run_op(16'd300, 16'd300, 0, 0);
        run_op(16'h1234, 16'h0000, 0, 0);
        // start during RUN, then during DONE, must both be ignored
        run_op(16'h0013, 16'h8001, 5, 0);
        run_op(16'd7, 16'd7, 0, 0);
        run_op(16'h0021, 16'h8003, 17, 0);
        run_op(16'hABCD, 16'h8001, 0, 8);
        run_op(16'd2, 16'd9, 0, 0);
        run_op(16'd2, 16'd1, 0, 0);
        run_op(16'd5, 16'h8000, 0, 0);
        for (int i = 0; i < 6; i++) begin
            run_op(16'($urandom), 16'($urandom), 0, 0);
        end

        repeat (25) @(negedge clk);
        check_eq("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mul16_seq.md
Name: mul16_seq

Overview:
- Multi-cycle 16x16 shift-and-add multiplier that acts as the initiator for the existing combinational ALU.
- It drives the ALU's six control bits and enable, and consumes the ALU output.
- It produces the low 16 bits of the product (Hack word semantics; identical for signed and unsigned operands).
- Sits beside the ALU in the execute stage and serves MUL instructions under a start/busy/done handshake.

Parameters:
- CNT_W, 5, width of the iteration counter; must hold 16.
- ITERS, 16, number of RUN iterations; only 16 is supported because the ALU is fixed at 16 bits.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  16  multiplicand; captured on accepted start.
- b  input  16  multiplier; captured on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the product becomes valid.
- product  output  16  last completed product; holds until the next completion.
- product_zr  output  1  product == 0.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - acc, mcand, mplier, cnt = 0.
  - product = 0, product_zr = 1, busy = 0, done = 0.
  - Reset mid-RUN aborts the operation; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 → load mcand=a, mplier=b, acc=0, cnt=0; next state RUN.
  - start=0 → stay in IDLE.
- RUN, each cycle:
  - Internal ALU instance: x=acc, y=mcand, zx=0 nx=0 zy=0 ny=0 f=1 no=0, enable=1, giving x+y modulo 2^16.
  - If mplier[0]=1, acc <= ALU out; otherwise acc holds.
  - mcand <= mcand<<1 (zero fill); mplier <= mplier>>1 (logical).
  - cnt <= cnt+1.
  - When cnt==ITERS-1, next state is DONE.
- DONE (one cycle):
  - product <= acc; product_zr <= (acc==0).
  - done=1 for this cycle only; next state IDLE.
- Latency: start sampled at edge t; busy high for cycles t+1..t+16; done high at t+17; product valid from t+17.
- start while in RUN or DONE is ignored and not queued; a new start is accepted in IDLE at the earliest at t+18.
- Operands a and b are don't-care outside the accepting edge.
- All additions wrap at 16 bits; no overflow flag.

Optional Feature:
- Macro: MUL16_SEQ_EARLY_EXIT_EN.
- With the macro: RUN also goes to DONE when the next mplier value is 0 (mplier>>1==0). Example: b=1 → 1 RUN cycle; b=0 → 1 RUN cycle.
- Without the macro: always exactly ITERS RUN cycles, so latency is fixed at 17 cycles from start to done.
- Result values are identical either way.

Decomposition:
- Shared package:
  - State encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - ALU control word constant ALU_OP_ADD (zx,nx,zy,ny,f,no = 000010), reusable by the decoder.
- Sub-module: instantiate the existing 16-bit alu for the accumulate step; no new sub-module is needed.

Test Plan:
- Basic multiply and timing: reset, then a=3 b=5 start pulse → busy for 16 cycles, done at cycle 17, product=0x000F, product_zr=0.
- Wrap-around: a=0xFFFF b=0xFFFF → product=0x0001; a=300 b=300 → product=0x5F90.
- Zero operand: a=0x1234 b=0 → product=0x0000, product_zr=1, done on schedule (17 cycles without macro).
- Start ignored when not idle: pulse start with a=7 b=7 at RUN cycle 5 → first op completes with its own product; second result never appears; a fresh start after done yields 49=0x0031.
- Reset mid-operation: assert rst at RUN cycle 8 → immediately busy=0, done=0, product=0; no done pulse follows; next op 2*9 → 0x0012.
- Early exit, with MUL16_SEQ_EARLY_EXIT_EN: a=2 b=1 → done 2 cycles after start, product=0x0002; a=5 b=0x8000 → full 16 RUN cycles, product=0x8000.
